prom_bank_dl: RTL and testbench

- Parametrised, runtime-loadable replacement for the fixed 82S129-style colour/palette PROMs (the 4-bit-per-entry lookup and RGB palette tables).
- Holds NCH independent channels of 2^AW x DW entries, e.g. 3 channels for R/G/B.
- Contents are filled from the MiSTer ioctl download byte stream, not synthesised constants.
- Presents one shared registered read address, returning all channels in parallel to the video pipeline, with a load-status state machine gating output validity.

---
 rtl/prom_bank_pkg.sv | 18 +
 rtl/prom_chan_ram.sv | 30 +++
 rtl/prom_bank_dl.sv | 133 +++++++++++++
 tb/tb_prom_bank_dl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/prom_bank_pkg.sv
// rtl/prom_bank_pkg.sv - shared types and helpers for the downloadable palette PROM bank
package prom_bank_pkg;

    localparam int IOCTL_AW = 25;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOADING,
        ST_CHECK,
        ST_READY,
        ST_ERROR
    } state_t;

    function automatic int image_size(input int nch, input int aw);
        return nch << aw;
    endfunction

endpackage

// File: rtl/prom_chan_ram.sv
// rtl/prom_chan_ram.sv - one palette channel: simple dual-port RAM, registered read-before-write
module prom_chan_ram #(
    parameter int AW = 8,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Single clocked process with non-blocking write: a same-cycle read of the written entry sees the old data.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/prom_bank_dl.sv
// rtl/prom_bank_dl.sv - runtime-loadable multi-channel colour PROM filled from the ioctl download stream
module prom_bank_dl
    import prom_bank_pkg::*;
#(
    parameter int          AW      = 8,
    parameter int          DW      = 4,
    parameter int          NCH     = 3,
    parameter logic [24:0] DL_BASE = 25'h0,
    parameter int          BLANK   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dl_download,
    input  logic              dl_wr,
    input  logic [24:0]       dl_addr,
    input  logic [7:0]        dl_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [NCH*DW-1:0] rd_data,
    output logic              rd_valid,
    output logic              loaded,
    output logic              load_err,
    output logic [AW+3:0]     wr_count
);

    localparam logic [IOCTL_AW-1:0] IMG_SIZE   = IOCTL_AW'(image_size(NCH, AW));
    localparam logic [AW+3:0]       IMG_CNT    = (AW+4)'(image_size(NCH, AW));
    localparam logic [NCH*DW-1:0]   BLANK_WORD = {NCH{BLANK[DW-1:0]}};

    state_t            state_q, state_d;
    logic [AW+3:0]     wr_count_q, wr_count_d;
    logic              dl_download_q;
    logic              dl_rise;

    logic [IOCTL_AW-1:0] off;
    logic                wr_hit;
    logic [NCH-1:0]      we;
    logic [NCH*DW-1:0]   ram_rdata;

    logic              rd_en_q;
    logic              blank_sel_q;
    logic              rd_valid_q;
    logic [NCH*DW-1:0] rd_data_q;

    // Addresses below DL_BASE wrap to a huge offset and fall out of range naturally.
    assign off     = dl_addr - DL_BASE;
    assign wr_hit  = dl_wr && (off < IMG_SIZE);
    assign dl_rise = dl_download && !dl_download_q;

    always_comb begin
        we = '0;
        for (int c = 0; c < NCH; c++) begin
            we[c] = wr_hit && (off[IOCTL_AW-1:AW] == (IOCTL_AW-AW)'(c));
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        prom_chan_ram #(
            .AW(AW),
            .DW(DW)
        ) u_ram (
            .clk    (clk),
            .we_i   (we[c]),
            .waddr_i(off[AW-1:0]),
            .wdata_i(dl_data[DW-1:0]),
            .re_i   (rd_en),
            .raddr_i(rd_addr),
            .rdata_o(ram_rdata[c*DW +: DW])
        );
    end

    if (DW < 8) begin : g_unused
        logic unused_dl_data;
        assign unused_dl_data = ^dl_data[7:DW];
    end

    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        case (state_q)
            ST_IDLE, ST_READY, ST_ERROR: begin
                if (dl_rise) begin
                    state_d    = ST_LOADING;
                    wr_count_d = '0;
                end
            end
            ST_LOADING: begin
                if (wr_hit && (wr_count_q != IMG_CNT)) begin
                    wr_count_d = wr_count_q + 1'b1;
                end
                if (!dl_download) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = (wr_count_q == IMG_CNT) ? ST_READY : ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            wr_count_q    <= '0;
            dl_download_q <= 1'b0;
            rd_en_q       <= 1'b0;
            blank_sel_q   <= 1'b1;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= BLANK_WORD;
        end else begin
            state_q       <= state_d;
            wr_count_q    <= wr_count_d;
            dl_download_q <= dl_download;
            rd_en_q       <= rd_en;
            // Validity is decided when the request is sampled, alongside the RAM address.
            blank_sel_q   <= (state_q != ST_READY);
            rd_valid_q    <= rd_en_q;
            if (rd_en_q) begin
                rd_data_q <= blank_sel_q ? BLANK_WORD : ram_rdata;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign loaded   = (state_q == ST_READY);
    assign load_err = (state_q == ST_ERROR);
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_prom_bank_dl.sv
// tb/tb_prom_bank_dl.sv - self-checking bench for prom_bank_dl against a behavioural palette model
module tb_prom_bank_dl;

    localparam logic [24:0] BASE = 25'h0001000;
    localparam int          IMG  = 768;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dl_download;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [11:0] rd_data;
    logic        rd_valid;
    logic        loaded;
    logic        load_err;
    logic [11:0] wr_count;

    always #5 clk = ~clk;

    prom_bank_dl #(
        .AW(8), .DW(4), .NCH(3), .DL_BASE(BASE), .BLANK(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .dl_download(dl_download), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .loaded(loaded), .load_err(load_err),
        .wr_count(wr_count)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  mm [3][256];
    bit          m_loaded  = 0;
    bit          m_loading = 0;
    int          m_count   = 0;
    logic [11:0] m_last    = 12'h000;

    function automatic logic [11:0] exp_read(input logic [7:0] a);
        if (!m_loaded) return 12'h000;
        return {mm[2][a], mm[1][a], mm[0][a]};
    endfunction

    task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
        logic [24:0] o;
        o = a - BASE;
        dl_wr = 1'b1; dl_addr = a; dl_data = d;
        if (int'(o) < IMG) begin
            mm[int'(o) / 256][int'(o) % 256] = d[3:0];
            if (m_loading && m_count < IMG) m_count++;
        end
        @(negedge clk);
        dl_wr = 1'b0;
    endtask

    task automatic download(input int nbytes, input bit pattern, input bit junk, input int abort_at);
        dl_download = 1'b1; m_loading = 1; m_count = 0; m_loaded = 0;
        @(negedge clk);
        for (int i = 0; i < nbytes; i++) begin
            if (i == abort_at) begin
                reset_n = 1'b0; dl_download = 1'b0; m_loading = 0; m_count = 0;
                @(negedge clk);
                reset_n = 1'b1; m_last = 12'h000;
                return;
            end
            write_byte(BASE + 25'(i), pattern ? 8'(i & 15) : 8'($urandom));
            if (junk && (i % 64 == 0)) begin
                write_byte(BASE + 25'(IMG), 8'hFF);
                write_byte(BASE - 25'd1, 8'hFF);
            end
        end
        dl_download = 1'b0; m_loading = 0; m_loaded = (m_count == IMG);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_read(input logic [7:0] a, output logic v, output logic [11:0] d);
        rd_en = 1'b1; rd_addr = a; m_last = exp_read(a);
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        v = rd_valid; d = rd_data;
    endtask

    task automatic test_reset;
        logic v; logic [11:0] d;
        reset_n = 1'b0; dl_download = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        rd_en = 1'b0; rd_addr = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        n_checks++; if (rd_data !== 12'h000) begin n_fail++; $display("FAIL reset_rd_data got %h want 000", rd_data); end
        n_checks++; if (loaded !== 1'b0) begin n_fail++; $display("FAIL reset_loaded got %b want 0", loaded); end
        n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL reset_load_err got %b want 0", load_err); end
        n_checks++; if (wr_count !== 12'd0) begin n_fail++; $display("FAIL reset_wr_count got %0d want 0", wr_count); end
        do_read(8'h10, v, d);
        n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL unloaded_read_valid got %b want 1", v); end
        n_checks++; if (d !== exp_read(8'h10)) begin n_fail++; $display("FAIL unloaded_read_data got %h want %h", d, exp_read(8'h10)); end
    endtask

    task automatic test_full_load;
        logic v; logic [11:0] d;
        download(IMG, 1'b1, 1'b0, -1);
        n_checks++; if (loaded !== 1'b1) begin n_fail++; $display("FAIL full_loaded got %b want 1", loaded); end
        n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL full_load_err got %b want 0", load_err); end
        n_checks++; if (wr_count !== 12'(m_count)) begin n_fail++; $display("FAIL full_wr_count got %0d want %0d", wr_count, m_count); end
        do_read(8'h05, v, d);
        n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL full_read_valid got %b want 1", v); end
        n_checks++; if (d !== 12'h555) begin n_fail++; $display("FAIL full_read_05 got %h want 555", d); end
    endtask

    task automatic test_collision;
        logic [11:0] e0, e1;
        rd_en = 1'b1; rd_addr = 8'h20; e0 = exp_read(8'h20);
        dl_wr = 1'b1; dl_addr = BASE + 25'h20; dl_data = 8'h0A;
        mm[0][8'h20] = 4'hA;
        @(negedge clk);
        dl_wr = 1'b0; rd_en = 1'b1; rd_addr = 8'h20; e1 = exp_read(8'h20);
        @(negedge clk);
        rd_en = 1'b0;
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== e0) begin n_fail++; $display("FAIL collision_old got %b/%h want 1/%h", rd_valid, rd_data, e0); end
        @(negedge clk);
        m_last = e1;
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 12'h00A) begin n_fail++; $display("FAIL collision_new got %b/%h want 1/00a", rd_valid, rd_data); end
        n_checks++; if (wr_count !== 12'd768) begin n_fail++; $display("FAIL collision_wr_count got %0d want 768", wr_count); end
    endtask

    task automatic test_short_load;
        logic v; logic [11:0] d; logic [7:0] a;
        download(700, 1'b0, 1'b0, -1);
        n_checks++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL short_load_err got %b want 1", load_err); end
        n_checks++; if (loaded !== 1'b0) begin n_fail++; $display("FAIL short_loaded got %b want 0", loaded); end
        n_checks++; if (wr_count !== 12'd700) begin n_fail++; $display("FAIL short_wr_count got %0d want 700", wr_count); end
        a = 8'($urandom);
        do_read(a, v, d);
        n_checks++; if (v !== 1'b1 || d !== 12'h000) begin n_fail++; $display("FAIL short_read_blank got %b/%h want 1/000", v, d); end
    endtask

    task automatic test_back_to_back(input int n, input bit seq, input bit wr);
        bit          qv[$];
        logic [11:0] qd[$];
        bit          ev;
        logic [11:0] ed, exp_d;
        logic [7:0]  a;
        int          o;
        for (int k = 0; k < n + 2; k++) begin
            if (k >= 2) begin
                ev = qv.pop_front(); ed = qd.pop_front();
                exp_d = ev ? ed : m_last;
                if (ev) m_last = ed;
                n_checks++; if (rd_valid !== ev) begin n_fail++; $display("FAIL b2b_valid k=%0d got %b want %b", k, rd_valid, ev); end
                n_checks++; if (rd_data !== exp_d) begin n_fail++; $display("FAIL b2b_data k=%0d got %h want %h", k, rd_data, exp_d); end
            end
            if (k < n) begin
                a = seq ? 8'(k) : 8'($urandom);
                rd_en = seq ? 1'b1 : ($urandom % 4 != 0);
                rd_addr = a;
                qv.push_back(rd_en); qd.push_back(exp_read(a));
                if (wr && ($urandom % 3 == 0)) begin
                    o = int'($urandom % IMG);
                    dl_wr = 1'b1; dl_addr = BASE + 25'(o); dl_data = 8'($urandom);
                    mm[o / 256][o % 256] = dl_data[3:0];
                end else begin
                    dl_wr = 1'b0;
                end
            end else begin
                rd_en = 1'b0; dl_wr = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_out_of_range;
        download(IMG, 1'b0, 1'b1, -1);
        n_checks++; if (loaded !== 1'b1) begin n_fail++; $display("FAIL oor_loaded got %b want 1", loaded); end
        n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL oor_load_err got %b want 0", load_err); end
        n_checks++; if (wr_count !== 12'd768) begin n_fail++; $display("FAIL oor_wr_count got %0d want 768", wr_count); end
        test_back_to_back(256, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_load;
        logic v; logic [11:0] d;
        download(IMG, 1'b0, 1'b0, 300);
        n_checks++; if (wr_count !== 12'd0) begin n_fail++; $display("FAIL abort_wr_count got %0d want 0", wr_count); end
        n_checks++; if (loaded !== 1'b0) begin n_fail++; $display("FAIL abort_loaded got %b want 0", loaded); end
        n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL abort_load_err got %b want 0", load_err); end
        n_checks++; if (rd_valid !== 1'b0 || rd_data !== 12'h000) begin n_fail++; $display("FAIL abort_rd got %b/%h want 0/000", rd_valid, rd_data); end
        do_read(8'h00, v, d);
        n_checks++; if (v !== 1'b1 || d !== 12'h000) begin n_fail++; $display("FAIL abort_read_blank got %b/%h want 1/000", v, d); end
        download(IMG, 1'b0, 1'b0, -1);
        n_checks++; if (loaded !== 1'b1) begin n_fail++; $display("FAIL reload_loaded got %b want 1", loaded); end
        n_checks++; if (wr_count !== 12'd768) begin n_fail++; $display("FAIL reload_wr_count got %0d want 768", wr_count); end
        test_back_to_back(300, 1'b0, 1'b1);
        test_back_to_back(256, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_collision();
        test_short_load();
        test_out_of_range();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
